// File: rtl/trace_pkg.sv
// Shared types for the commit-trace recorder: record kinds, the default record
// layout, lane count and FSM states.
package trace_pkg;

    localparam int REC_ADDR_W  = 16;
    localparam int REC_DATA_W  = 16;
    localparam int REC_CNT_W   = 32;
    localparam int TRACE_LANES = 3;

    typedef enum logic [1:0] {
        KIND_REG   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_HALT  = 2'd3
    } trace_kind_e;

    // Field order matches the packed record vector used inside the recorder.
    typedef struct packed {
        trace_kind_e             kind;
        logic [REC_ADDR_W-1:0]   addr;
        logic [REC_DATA_W-1:0]   data;
        logic [REC_CNT_W-1:0]    cycle;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO: three prioritised write lanes per cycle, one first-word-fall-through
// read. Pointers carry an extra MSB so full and empty are distinguishable.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int W     = 66,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TRACE_LANES-1:0]        wr_valid,
    input  logic [TRACE_LANES-1:0][W-1:0] wr_data,
    output logic [1:0]                    wr_accepted,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [W-1:0]                  rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]           mem [DEPTH];
    logic [AW:0]            wr_ptr_reg;
    logic [AW:0]            rd_ptr_reg;
    logic [AW:0]            used;
    logic [AW:0]            free;
    logic [AW:0]            n_take;
    logic [AW:0]            rank [TRACE_LANES];
    logic [TRACE_LANES-1:0] take;
    logic                   pop;

    function automatic logic [AW:0] ones(input logic [TRACE_LANES-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < TRACE_LANES; i++) begin
            n = n + {{AW{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Free space uses pre-pop occupancy; a same-cycle pop frees nothing yet.
    assign used = wr_ptr_reg - rd_ptr_reg;
    assign free = (AW+1)'(DEPTH) - used;

    // Valid lanes are packed into consecutive slots; a lane lands only if
    // the slots taken by earlier valid lanes still leave room for it.
    generate
        for (genvar gi = 0; gi < TRACE_LANES; gi++) begin : g_lane
            localparam logic [TRACE_LANES-1:0] BELOW = TRACE_LANES'((1 << gi) - 1);
            assign rank[gi] = ones(wr_valid & BELOW);
            assign take[gi] = wr_valid[gi] && (rank[gi] < free);
        end
    endgenerate

    assign n_take      = ones(take);
    assign wr_accepted = n_take[1:0];
    assign rd_valid    = (used != '0);
    assign pop         = rd_valid && rd_ready;
    assign rd_data     = rd_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + n_take;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < TRACE_LANES; i++) begin
            if (take[i]) begin
                mem[AW'(wr_ptr_reg + rank[i])] <= wr_data[i];
            end
        end
    end

endmodule

// File: rtl/trace_capture_unit.sv
// Commit-trace recorder: packs REG/LOAD/STORE/HALT events into timestamped records
// and keeps instruction/cycle/drop statistics. Watchdog built only with TRACE_WATCHDOG_EN.
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              hlt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_kind,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_cycle,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              done,
    output logic              timeout
);

    localparam int                REC_W   = 2 + ADDR_W + DATA_W + CNT_W;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    trace_state_e                         state_reg;
    logic [CNT_W-1:0]                     inst_count_reg;
    logic [CNT_W-1:0]                     cycle_count_reg;
    logic [CNT_W-1:0]                     drop_count_reg;
    logic [CNT_W-1:0]                     inst_next;
    logic [CNT_W-1:0]                     cycle_next;
    logic [CNT_W-1:0]                     drop_next;
    logic                                 done_reg;
    logic                                 timeout_reg;
    logic                                 run;
    logic                                 cap;
    logic                                 inst_inc;
    logic                                 wdog_fire;
    logic                                 fifo_valid;
    logic [TRACE_LANES-1:0]               ev;
    logic [TRACE_LANES-1:0][REC_W-1:0]    lane_rec;
    logic [1:0]                           accepted;
    logic [1:0]                           n_ev;
    logic [REC_W-1:0]                     head;
    trace_kind_e                          mem_kind;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    assign run = (state_reg == ST_RUN);
    assign cap = run && en;

    // Lane order is the record order: REG, then LOAD/STORE, then HALT.
    assign ev       = {cap && hlt, cap && (mem_rd || mem_wr), cap && wb_we};
    assign n_ev     = {1'b0, ev[0]} + {1'b0, ev[1]} + {1'b0, ev[2]};
    assign inst_inc = cap && (hlt || wb_we || mem_wr);

    assign inst_next  = sat_add(inst_count_reg, {1'b0, inst_inc});
    assign cycle_next = sat_add(cycle_count_reg, 2'd1);
    assign drop_next  = sat_add(drop_count_reg, n_ev - accepted);

    assign mem_kind    = mem_wr ? KIND_STORE : KIND_LOAD;
    assign lane_rec[0] = {KIND_REG, ADDR_W'(wb_reg), wb_data, cycle_count_reg};
    assign lane_rec[1] = {mem_kind, mem_addr, (mem_wr ? mem_wdata : mem_rdata), cycle_count_reg};
    // HALT reports the count including the halt cycle itself.
    assign lane_rec[2] = {KIND_HALT, {ADDR_W{1'b0}}, inst_next[DATA_W-1:0], cycle_count_reg};

`ifdef TRACE_WATCHDOG_EN
    assign wdog_fire = run && (cycle_count_reg == CNT_W'(WDOG_LIMIT - 1));
`else
    logic unused_wdog;
    assign unused_wdog = ^CNT_W'(WDOG_LIMIT);
    assign wdog_fire   = 1'b0;
`endif

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (ev),
        .wr_data     (lane_rec),
        .wr_accepted (accepted),
        .rd_valid    (fifo_valid),
        .rd_ready    (out_ready),
        .rd_data     (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            inst_count_reg  <= '0;
            cycle_count_reg <= '0;
            drop_count_reg  <= '0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (en) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cycle_count_reg <= cycle_next;
                    inst_count_reg  <= inst_next;
                    drop_count_reg  <= drop_next;
                    if (wdog_fire) begin
                        timeout_reg <= 1'b1;
                    end
                    if (ev[2] || wdog_fire) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!fifo_valid) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_DONE;
                end
            endcase
        end
    end

    assign out_valid                                = fifo_valid;
    assign {out_kind, out_addr, out_data, out_cycle} = head;
    assign inst_count                               = inst_count_reg;
    assign cycle_count                              = cycle_count_reg;
    assign drop_count                               = drop_count_reg;
    assign done                                     = done_reg;
    assign timeout                                  = timeout_reg;

endmodule

// File: doc/trace_capture_unit.md
# trace_capture_unit

Synthesizable commit-trace recorder for the 16-bit pipelined CPU. It watches the writeback and memory-stage commit signals and packs every register write, load, store and halt into timestamped records. Records are buffered in an on-chip multi-write FIFO and drained over a valid/ready port. It also keeps instruction and cycle counters and a watchdog, giving silicon and FPGA builds the same REG/LOAD/STORE trace and statistics that the simulation bench produces.

## Interface
- DATA_W, 16, register and memory data width
- ADDR_W, 16, memory address width; also the record address field width
- REG_W, 4, register index width (REG_W <= ADDR_W)
- DEPTH, 16, FIFO entries; power of two, >= 4
- CNT_W, 32, counter and timestamp width
- WDOG_LIMIT, 100000, cycle count at which the watchdog fires
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  capture enable; starts the run
- wb_we / wb_reg / wb_data  in  1 / REG_W / DATA_W  writeback register write
- mem_rd / mem_wr  in  1 / 1  memory-stage load / store (mutually exclusive)
- mem_addr / mem_wdata / mem_rdata  in  ADDR_W / DATA_W / DATA_W  memory-stage access
- hlt  in  1  halt reached writeback
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_kind  out  2  0 REG, 1 LOAD, 2 STORE, 3 HALT
- out_addr  out  ADDR_W  register index (zero-extended) or memory address
- out_data  out  DATA_W  write data, load data, or inst_count[DATA_W-1:0] for HALT
- out_cycle  out  CNT_W  cycle_count when the event occurred
- inst_count, cycle_count, drop_count  out  CNT_W each  statistics
- done, timeout  out  1 each  status

## Operation
- FSM states:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when hlt=1 or the watchdog fires.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE holds until reset.
- en=0 in RUN does not change state. Events are ignored while en=0.
- Capture happens only in RUN with en=1. Up to three events per cycle, written in this order:
  - REG (wb_we)
  - LOAD (mem_rd) or STORE (mem_wr)
  - HALT (hlt)
- Free space is evaluated on pre-pop occupancy, so a pop does not free a slot in the same cycle.
- Events are accepted in order until the FIFO is full. Each remaining event increments drop_count (saturating).
- inst_count increments by 1 in RUN when hlt|wb_we|mem_wr. It counts even when records are dropped.
- cycle_count increments every RUN cycle. Both counters saturate at all-ones and freeze outside RUN.
- LOAD records carry mem_rdata. STORE records carry mem_wdata.
- HALT records carry inst_count after including the halt cycle's own increment.
- out_* are first-word-fall-through from the FIFO head. A pop occurs when out_valid&out_ready.
- Reset mid-run clears the FIFO, all counters and all status bits, and returns the FSM to IDLE.
- Reset values: out_valid=0, done=0, timeout=0, all counters 0, out_kind/out_addr/out_data/out_cycle 0.

## Timing
- An event sampled at edge N is visible with out_valid=1 after edge N, i.e. in cycle N+1.
- Throughput: 3 writes and 1 read per cycle.
- Records stay stable while out_valid=1 and out_ready=0.
- done rises on the edge after the last pop in DRAIN. If DRAIN is entered with an empty FIFO, done rises on the following edge.
- Watchdog: on the edge where cycle_count becomes WDOG_LIMIT, timeout is set (sticky) and the FSM enters DRAIN. Events in that cycle are still captured.
- hlt and a watchdog fire in the same cycle: DRAIN is entered, timeout=1, and the HALT record is written.

## Configuration
- TRACE_WATCHDOG_EN defined: the watchdog operates as above.
- Undefined: no comparator is built, timeout is tied to 0, and only hlt ends a run. cycle_count still saturates.

## Structure
- Package trace_pkg holds:
  - the trace_kind_e enum (REG/LOAD/STORE/HALT)
  - the trace_rec_t struct (kind, addr, data, cycle)
  - the FSM state enum
- Sub-module trace_fifo, generic over record width and DEPTH:
  - 3-lane priority write with accepted-count output
  - single FWFT read
  - wrap-around pointers with an extra MSB for full/empty

## Test plan
- **Single write:** en=1, wb_we=1 with reg 5, data 0x00A3 at cycle 3 -> one record: REG, addr 0x0005, data 0x00A3, out_cycle 3; inst_count=1.
- **Dual event:** same cycle wb_we (reg 2, 0x1111) and mem_wr (addr 0x0040, wdata 0xBEEF) -> REG record then STORE record, in that order; inst_count +1.
- **Overflow:** DEPTH=4, out_ready=0, 6 REG events -> 4 records held, drop_count=2, out_valid steady; then out_ready=1 -> 4 pops in order.
- **Halt:** hlt after 10 counted instructions -> HALT record with data 0x000B; state DRAIN; done=1 one edge after the last pop; later events are ignored.
- **Watchdog (with TRACE_WATCHDOG_EN):** WDOG_LIMIT=20, no hlt -> timeout=1 when cycle_count=20, counters frozen, then done after drain. Without the macro -> timeout stays 0.
- **Reset:** rst_n=0 for 1 edge with 3 records queued -> out_valid=0, all counters 0, IDLE; recapture works after en.
